// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
//
// Forwarding and load-use hazard unit for the pipelined MIPS core. It sits at
// the ID/EX boundary and keeps its own DEPTH-entry history of in-flight
// destinations, so it needs no rd/regWrite fields from later pipeline stages.
//
// Entry 0 is EX/MEM. Entry DEPTH-1 is the last stage before the register-file
// write becomes visible. The history shifts by one entry on every clock edge.
//
// Parameters
//   REG_W      register-index width
//   NUM_SRC    source operands per instruction
//   DEPTH      number of tracked stages after EX
//   LOAD_READY lowest entry index at which a load result can be forwarded
//   SEL_W      width of one select field (derived)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   issue_valid  instruction in ID/EX is real (not a bubble)
//   issue_wr     instruction writes a register
//   issue_load   instruction is a load
//   issue_rd     destination register
//   flush        squash all in-flight entries
//   src_rs       packed source indices; source i at [i*REG_W +: REG_W]
//   src_used     source i is actually read
//   fw_sel       per-source select; 0 = register file, k+1 = entry k
//   stall        load-use hazard; hold ID/EX and issue nothing
//   stall_cnt    saturating stall-cycle count
//   fwd_cnt      saturating forwarded-operand count
//
// Optional feature: define FWD_STATS_EN to build the two statistics counters.
// Without it, stall_cnt and fwd_cnt are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module fwd_scoreboard #(
  parameter  int REG_W      = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int DEPTH      = 2,
  parameter  int LOAD_READY = 1,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic                       issue_wr,
  input  logic                       issue_load,
  input  logic [REG_W-1:0]           issue_rd,
  input  logic                       flush,
  input  logic [NUM_SRC*REG_W-1:0]   src_rs,
  input  logic [NUM_SRC-1:0]         src_used,
  output logic [NUM_SRC*SEL_W-1:0]   fw_sel,
  output logic                       stall,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                fwd_cnt
);

  typedef struct packed {
    logic             v;
    logic             wr;
    logic             ld;
    logic [REG_W-1:0] rd;
  } entry_t;

  entry_t            ent [DEPTH];
  logic [SEL_W-1:0]  sel [NUM_SRC];
  logic [NUM_SRC-1:0] haz;

  // ---------------------------------------------------------------------------
  // Match and select. Entries are scanned from oldest to youngest, so the last
  // hit (the lowest k) wins. This is how a younger writer hides an older one.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      // NOTE: every output of this block gets a default before the conditional
      // scan. Otherwise a path with no match would hold the old value, and a
      // latch would be inferred.
      sel[i] = '0;
      haz[i] = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent[k].v && ent[k].wr && src_used[i] &&
            (ent[k].rd != '0) &&
            (ent[k].rd == src_rs[i*REG_W +: REG_W])) begin
          sel[i] = SEL_W'(k + 1);
          // A load that has not yet reached LOAD_READY cannot supply its data.
          haz[i] = ent[k].ld && (k < LOAD_READY);
        end
      end
    end
  end

  assign stall = |haz;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sel
    assign fw_sel[gi*SEL_W +: SEL_W] = sel[gi];
  end

  // ---------------------------------------------------------------------------
  // History shift register. A stalled or invalid issue enters as a bubble.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the history is reset in full, not just the valid bits. It is
      // only DEPTH small flops, and a fully clean state after reset costs
      // nothing.
      for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every entry sample its neighbour's
      // pre-edge value. Blocking assignments would depend on loop order and
      // could collapse the shift.
      for (int k = DEPTH - 1; k >= 1; k--) ent[k] <= ent[k-1];
      if (stall || !issue_valid) ent[0] <= '0;
      else                       ent[0] <= '{v: 1'b1, wr: issue_wr,
                                             ld: issue_load, rd: issue_rd};
    end
  end

`ifdef FWD_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters; both saturate at all-ones.
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cnt_q;
  logic [15:0] fwd_cnt_q;
  logic [15:0] fwd_inc;
  logic [16:0] fwd_sum;

  always_comb begin
    fwd_inc = '0;
    for (int i = 0; i < NUM_SRC; i++) fwd_inc = fwd_inc + 16'(sel[i] != '0);
  end

  assign fwd_sum = {1'b0, fwd_cnt_q} + {1'b0, fwd_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (issue_valid && !stall && !flush)
        fwd_cnt_q <= fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule
